// File: rtl/ohsm_pkg.sv
// Shared definitions for the ohsm stage responder: SGlobal codes, FSM states,
// error bit positions and code helpers.
package ohsm_pkg;

    localparam logic [2:0] SG_IDLE = 3'b000;
    localparam logic [2:0] SG_S1   = 3'b001;
    localparam logic [2:0] SG_S2   = 3'b010;
    localparam logic [2:0] SG_S3   = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } resp_state_t;

    localparam int ERR_ILL = 0;
    localparam int ERR_ORD = 1;
    localparam int ERR_OVR = 2;

    function automatic logic [1:0] stage_of(input logic [2:0] code);
        case (code)
            SG_S1:   return 2'd1;
            SG_S2:   return 2'd2;
            SG_S3:   return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic is_legal(input logic [2:0] code);
        return (code == SG_IDLE) || (code == SG_S1) || (code == SG_S2) || (code == SG_S3);
    endfunction

    // The sequencer walks idle -> S1 -> S2 -> S3 -> S1 ..., and may drop to idle anywhere.
    function automatic logic order_ok(input logic [2:0] prev, input logic [2:0] next);
        return (next == SG_IDLE) ||
               (prev == SG_IDLE && next == SG_S1) ||
               (prev == SG_S1   && next == SG_S2) ||
               (prev == SG_S2   && next == SG_S3) ||
               (prev == SG_S3   && next == SG_S1);
    endfunction

endpackage

// File: rtl/ohsm_resp_timer.sv
// Loadable down-counter that stops at zero; zero flags the last cycle of a stage.
module ohsm_resp_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (load)
            cnt <= val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ohsm_resp.sv
// Stage responder watching the ohsm SGlobal bus: runs a fixed-length action per stage
// and flags bad codes and overruns. Define OHSM_RESP_SEQCHK_EN to build the order checker.
module ohsm_resp
    import ohsm_pkg::*;
#(
    parameter int DUR_S1 = 4,
    parameter int DUR_S2 = 8,
    parameter int DUR_S3 = 2,
    parameter int CNT_W  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] SGlobal,
    input  logic       err_clr,
    output logic       busy,
    output logic       stage_done,
    output logic [1:0] cur_stage,
    output logic [7:0] done_cnt,
    output logic [2:0] err
);

    logic [2:0]       s_q;
    resp_state_t      state;
    logic             chg;
    logic             new_stage;
    logic [CNT_W-1:0] load_val;
    logic [2:0]       err_set;
    logic             tmr_en;
    logic             tmr_zero;

    always_comb begin
        chg       = (SGlobal != s_q);
        new_stage = chg && is_legal(SGlobal) && (SGlobal != SG_IDLE);
        case (stage_of(SGlobal))
            2'd1:    load_val = CNT_W'(DUR_S1 - 1);
            2'd2:    load_val = CNT_W'(DUR_S2 - 1);
            2'd3:    load_val = CNT_W'(DUR_S3 - 1);
            default: load_val = '0;
        endcase
        err_set          = '0;
        err_set[ERR_ILL] = chg && !is_legal(SGlobal);
        // Leaving RUN for another stage, even on the counter's last edge, is an overrun.
        err_set[ERR_OVR] = new_stage && (state == RUN);
`ifdef OHSM_RESP_SEQCHK_EN
        err_set[ERR_ORD] = new_stage && is_legal(s_q) && !order_ok(s_q, SGlobal);
`endif
    end

    assign tmr_en = (state == RUN) && !chg;

    ohsm_resp_timer #(.CNT_W(CNT_W)) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (new_stage),
        .val   (load_val),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            s_q        <= SG_IDLE;
            state      <= IDLE;
            busy       <= 1'b0;
            stage_done <= 1'b0;
            cur_stage  <= 2'd0;
            done_cnt   <= 8'd0;
            err        <= 3'b000;
        end else begin
            s_q        <= SGlobal;
            stage_done <= 1'b0;
            // A fresh error on the clearing edge survives the clear.
            err        <= (err_clr ? 3'b000 : err) | err_set;
            if (chg) begin
                if (new_stage) begin
                    state     <= RUN;
                    busy      <= 1'b1;
                    cur_stage <= stage_of(SGlobal);
                end else begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cur_stage <= 2'd0;
                end
            end else if (state == RUN && tmr_zero) begin
                state      <= HOLD;
                busy       <= 1'b0;
                stage_done <= 1'b1;
                done_cnt   <= done_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ohsm_resp.sv
// Directed bench for ohsm_resp with default durations S1=4, S2=8, S3=2.
module tb_ohsm_resp;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] SGlobal = 3'b000;
    logic       err_clr = 1'b0;
    logic       busy;
    logic       stage_done;
    logic [1:0] cur_stage;
    logic [7:0] done_cnt;
    logic [2:0] err;

    int checks = 0;
    int failures = 0;

`ifdef OHSM_RESP_SEQCHK_EN
    localparam logic [2:0] ORD_BIT = 3'b010;
`else
    localparam logic [2:0] ORD_BIT = 3'b000;
`endif

    ohsm_resp dut (
        .clk        (clk),
        .reset      (reset),
        .SGlobal    (SGlobal),
        .err_clr    (err_clr),
        .busy       (busy),
        .stage_done (stage_done),
        .cur_stage  (cur_stage),
        .done_cnt   (done_cnt),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset   = 1'b1;
        SGlobal = 3'b000;
        err_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Counts busy cycles from the sample after the detecting edge; bounded.
    task automatic wait_done(output int n);
        n = 0;
        while (busy === 1'b1 && n < 300) begin
            n++;
            step();
        end
    endtask

    task automatic run_stage(input string tag, input logic [2:0] code, input int dur);
        int n;
        SGlobal = code;
        step();
        wait_done(n);
        chk({tag, "_busy_len"}, n, dur);
        chk({tag, "_done_pulse"}, stage_done, 1'b1);
    endtask

    initial begin
        int n;
        logic [2:0] seq [3];
        int durs [3];
        seq  = '{3'b001, 3'b010, 3'b100};
        durs = '{4, 8, 2};

        // Reset state
        do_reset();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", stage_done, 1'b0);
        chk("rst_stage", cur_stage, 2'd0);
        chk("rst_cnt", done_cnt, 8'd0);
        chk("rst_err", err, 3'b000);

        // Single S1 held 10 cycles
        run_stage("s1", 3'b001, 4);
        chk("s1_cnt", done_cnt, 8'd1);
        chk("s1_stage", cur_stage, 2'd1);
        chk("s1_err", err, 3'b000);
        chk("s1_busy_low", busy, 1'b0);
        step();
        chk("s1_pulse_end", stage_done, 1'b0);
        repeat (4) step();
        chk("s1_hold_busy", busy, 1'b0);
        chk("s1_hold_cnt", done_cnt, 8'd1);

        // Full loop; each next code lands while stage_done is high
        run_stage("loop_s2", 3'b010, 8);
        run_stage("loop_s3", 3'b100, 2);
        run_stage("loop_s1", 3'b001, 4);
        chk("loop_cnt", done_cnt, 8'd4);
        chk("loop_err", err, 3'b000);

        // Overrun: S1 abandoned after 2 cycles
        do_reset();
        SGlobal = 3'b001;
        step();
        step();
        SGlobal = 3'b010;
        step();
        chk("ovr_err", err, 3'b100);
        chk("ovr_no_done", stage_done, 1'b0);
        chk("ovr_stage", cur_stage, 2'd2);
        chk("ovr_cnt0", done_cnt, 8'd0);
        wait_done(n);
        chk("ovr_s2_len", n, 8);
        chk("ovr_s2_done", stage_done, 1'b1);
        chk("ovr_s2_cnt", done_cnt, 8'd1);

        // Out-of-order 000 -> 100
        do_reset();
        SGlobal = 3'b100;
        step();
        chk("ord_err", err, ORD_BIT);
        chk("ord_stage", cur_stage, 2'd3);
        wait_done(n);
        chk("ord_s3_len", n, 2);
        chk("ord_s3_cnt", done_cnt, 8'd1);

        // Illegal code and err_clr
        SGlobal = 3'b011;
        step();
        chk("ill_err", err, ORD_BIT | 3'b001);
        chk("ill_stage", cur_stage, 2'd0);
        chk("ill_busy", busy, 1'b0);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr_err", err, 3'b000);
        err_clr = 1'b1;
        SGlobal = 3'b101;
        step();
        err_clr = 1'b0;
        chk("clr_vs_new_err", err, 3'b001);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        chk("clr2_err", err, 3'b000);

        // Drop to idle mid-stage: silent
        SGlobal = 3'b000;
        step();
        SGlobal = 3'b001;
        step();
        step();
        SGlobal = 3'b000;
        step();
        chk("drop_busy", busy, 1'b0);
        chk("drop_stage", cur_stage, 2'd0);
        chk("drop_err", err, 3'b000);
        chk("drop_done", stage_done, 1'b0);
        chk("drop_cnt", done_cnt, 8'd1);

        // Change on the very edge the counter reaches zero
        SGlobal = 3'b001;
        step();
        repeat (3) step();
        chk("edge_busy_last", busy, 1'b1);
        SGlobal = 3'b010;
        step();
        chk("edge_ovr_err", err, 3'b100);
        chk("edge_no_done", stage_done, 1'b0);
        chk("edge_cnt", done_cnt, 8'd1);
        chk("edge_stage", cur_stage, 2'd2);
        chk("edge_busy", busy, 1'b1);

        // Reset during cycle 3 of S2
        step();
        step();
        reset   = 1'b1;
        SGlobal = 3'b000;
        step();
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_done", stage_done, 1'b0);
        chk("mid_rst_stage", cur_stage, 2'd0);
        chk("mid_rst_cnt", done_cnt, 8'd0);
        chk("mid_rst_err", err, 3'b000);
        reset = 1'b0;
        step();

        // 256 completed stages wrap done_cnt
        for (int i = 0; i < 256; i++) begin
            SGlobal = seq[i % 3];
            step();
            wait_done(n);
            chk("wrap_len", n, durs[i % 3]);
            if (i == 254)
                chk("wrap_cnt255", done_cnt, 8'd255);
        end
        chk("wrap_cnt0", done_cnt, 8'd0);
        chk("wrap_err", err, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ohsm_resp.md
# ohsm_resp

Stage responder for the one-hot sequencer `ohsm`. It watches the sequencer's `SGlobal` state bus and runs a per-stage, fixed-duration action. It reports `busy` and a one-cycle `stage_done` for each completed stage. It also flags malformed bus codes, out-of-order transitions and stages that are abandoned before they finish. It sits downstream of `ohsm` and is the consumer end of the `SGlobal` interface.

## Interface
- `DUR_S1`, default 4: cycles of work for stage S1; must be at least 1.
- `DUR_S2`, default 8: cycles of work for stage S2; must be at least 1.
- `DUR_S3`, default 2: cycles of work for stage S3; must be at least 1.
- `CNT_W`, default 8: duration counter width; every `DUR_*` must be at most 2^CNT_W.
- `clk`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `SGlobal`  in  3  sequencer state code: 000 idle, 001 S1, 010 S2, 100 S3; any other code is illegal.
- `err_clr`  in  1  clears `err` on the next edge.
- `busy`  out  1  high while a stage's work is running.
- `stage_done`  out  1  one-cycle pulse when a stage finishes.
- `cur_stage`  out  2  binary code of the active or last stage: 0 idle, 1 S1, 2 S2, 3 S3.
- `done_cnt`  out  8  number of completed stages; wraps 255 -> 0.
- `err`  out  3  sticky error flags: [0] illegal code, [1] order violation, [2] overrun.

## Operation
- Internal register `s_q` holds the `SGlobal` value from the previous edge.
- A stage change is detected at an edge when `SGlobal != s_q`.
- FSM states are IDLE, RUN and HOLD.
- Change to a legal nonzero code, from any state:
  - go to RUN;
  - load counter with the stage's `DUR - 1`;
  - update `cur_stage`.
- RUN:
  - counter decrements every edge;
  - at an edge where counter == 0, go to HOLD, pulse `stage_done` and increment `done_cnt`.
- HOLD: waits with `busy` low for the next change.
- Change to 000, from any state:
  - go to IDLE with `cur_stage` = 0;
  - no error is raised;
  - an in-progress stage is dropped without setting the overrun flag.
- Change to an illegal code (not one-hot and not 000):
  - set `err[0]`;
  - go to IDLE with `cur_stage` = 0.
- Change to a legal nonzero code while in RUN:
  - set `err[2]`;
  - the old stage is dropped and produces no `stage_done` and no `done_cnt` increment;
  - the new stage starts normally.
- Order check (see Configuration). Allowed transitions are:
  - 000 -> 001, 001 -> 010, 010 -> 100, 100 -> 001;
  - any code -> 000.
  - Any other legal-to-legal change sets `err[1]`, but the new stage still runs.
- `err` bits are sticky, OR-accumulated, and cleared only by `reset` or `err_clr`.
- If `err_clr` and a new error land on the same edge, the new error wins: the bit ends up set.
- When `SGlobal` holds steady, nothing changes; re-entering the same code is not a new stage.

## Timing
- Reset values: all outputs 0; `s_q` = 000; FSM in IDLE; counter 0.
- `reset` takes priority over every other input.
- Reset asserted mid-stage aborts the stage silently.
- Detection latency is zero: the detecting edge itself loads the counter.
- `busy` is high for exactly `DUR` cycles, starting the cycle after the detecting edge.
- `stage_done` is registered. It is high for the one cycle right after `busy` falls; it coincides with `busy` low and `done_cnt` already incremented.
- A change on the same edge where the counter hits 0 counts as an overrun: the new stage wins, with no `stage_done` for the old one.
- A new stage may start in the very cycle `stage_done` is high; this is not an overrun.

## Configuration
- `OHSM_RESP_SEQCHK_EN` defined: the order checker is compiled in and drives `err[1]`.
- Not defined: no checker logic; `err[1]` is tied to 0; any legal-to-legal change is accepted silently.

## Structure
- Package `ohsm_pkg` holds:
  - stage codes `SG_IDLE`, `SG_S1`, `SG_S2`, `SG_S3`;
  - the FSM state enum `resp_state_t`;
  - error bit indices `ERR_ILL`, `ERR_ORD`, `ERR_OVR`;
  - a function mapping one-hot code to binary stage.
- Sub-module `ohsm_resp_timer`: a loadable `CNT_W`-bit down-counter with `load`, `val`, `en` inputs and a `zero` flag output.

## Test plan
- Reset, then `SGlobal` 000 -> 001 held 10 cycles:
  - `busy` high for 4 cycles, then `stage_done` for 1 cycle;
  - `done_cnt` = 1, `cur_stage` = 1, `err` = 000.
- Full loop 001 -> 010 -> 100 -> 001, each code held until `stage_done`:
  - busy lengths 4, 8, 2, 4;
  - `done_cnt` = 4, `err` = 000.
- 001 held 2 cycles, then 010:
  - `err` = 100 and no `stage_done` for S1;
  - S2 then completes after 8 cycles with `done_cnt` = 1.
- 000 -> 100 with macro defined: `err` = 010 and S3 completes. Same stimulus without the macro: `err` = 000.
- `SGlobal` = 011: `err[0]` set, `cur_stage` = 0, `busy` = 0. Then `err_clr` pulse gives `err` = 000 on the next cycle.
- `reset` asserted mid-S2 (cycle 3 of 8): every output is 0 next cycle. Then 256 completed stages wrap `done_cnt` to 0.
